// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with a bounded hold time per grant.
// The one-hot grant comes from a dec2to4 instance fed by the registered index/enable.

module dec2to4 (
  input  logic [1:0] i_idx,
  input  logic       i_en,
  output logic [3:0] o_dec
);

  always_comb begin
    o_dec = 4'b0000;
    if (i_en) begin
      o_dec[i_idx] = 1'b1;
    end
  end

endmodule

module rr_arb4 #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HW       = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_req,
  input  logic       i_done,
  output logic [1:0] o_grant_idx,
  output logic       o_grant_en,
  output logic [3:0] o_grant,
  output logic       o_timeout
);

  typedef enum logic {
    StIdle,
    StGrant
  } state_e;

  localparam logic [HW-1:0] HoldLast = HW'(MAX_HOLD - 1);

  state_e        r_st;
  logic [1:0]    r_ptr;
  logic [1:0]    r_owner;
  logic [HW-1:0] r_hold_cnt;
  logic          r_timeout;

  state_e        w_st_next;
  logic [1:0]    w_ptr_next;
  logic [1:0]    w_owner_next;
  logic [HW-1:0] w_hold_next;
  logic          w_timeout_next;

  logic [1:0]    w_pick;
  logic          w_pick_valid;
  logic          w_rel_done;
  logic          w_rel_drop;
  logic          w_rel_max;
  logic          w_release;

  // Walk offsets 3..0 so the smallest offset from r_ptr with a request wins.
  always_comb begin
    logic [1:0] cand;
    w_pick       = 2'd0;
    w_pick_valid = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      cand = r_ptr + 2'(i);
      if (i_req[cand]) begin
        w_pick       = cand;
        w_pick_valid = 1'b1;
      end
    end
  end

  assign w_rel_done = i_done;
  assign w_rel_drop = ~i_req[r_owner];
  assign w_rel_max  = (r_hold_cnt == HoldLast);
  assign w_release  = w_rel_done | w_rel_drop | w_rel_max;

  always_comb begin
    w_st_next      = r_st;
    w_ptr_next     = r_ptr;
    w_owner_next   = r_owner;
    w_hold_next    = r_hold_cnt;
    w_timeout_next = 1'b0;
    unique case (r_st)
      StIdle: begin
        if (w_pick_valid) begin
          w_owner_next = w_pick;
          w_hold_next  = '0;
          w_st_next    = StGrant;
        end
      end
      StGrant: begin
        if (w_release) begin
          w_st_next      = StIdle;
          w_ptr_next     = r_owner + 2'd1;
          w_hold_next    = '0;
          // A timeout is reported only when the hold limit alone ends the grant.
          w_timeout_next = w_rel_max & ~w_rel_done & ~w_rel_drop;
        end else begin
          w_hold_next = r_hold_cnt + HW'(1);
        end
      end
      default: begin
        w_st_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_st       <= StIdle;
      r_ptr      <= 2'd0;
      r_owner    <= 2'd0;
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_st       <= w_st_next;
      r_ptr      <= w_ptr_next;
      r_owner    <= w_owner_next;
      r_hold_cnt <= w_hold_next;
      r_timeout  <= w_timeout_next;
    end
  end

  assign o_grant_idx = r_owner;
  assign o_grant_en  = (r_st == StGrant);
  assign o_timeout   = r_timeout;

  dec2to4 u_dec (
    .i_idx (r_owner),
    .i_en  (o_grant_en),
    .o_dec (o_grant)
  );

endmodule

// File: tb/tb_rr_arb4.sv
// Directed bench for rr_arb4: three instances with MAX_HOLD of 8, 4 and 1.

module tb_rr_arb4;

  logic       clk;
  logic       rst, done;
  logic [3:0] req;
  logic [1:0] grant_idx;
  logic       grant_en, timeout;
  logic [3:0] grant;

  logic       rst4, done4;
  logic [3:0] req4;
  logic [1:0] grant_idx4;
  logic       grant_en4, timeout4;
  logic [3:0] grant4;

  logic       rst1, done1;
  logic [3:0] req1;
  logic [1:0] grant_idx1;
  logic       grant_en1, timeout1;
  logic [3:0] grant1;

  int n_chk;
  int n_err;

  rr_arb4 #(.MAX_HOLD(8), .HW(8)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_done(done),
    .o_grant_idx(grant_idx), .o_grant_en(grant_en), .o_grant(grant), .o_timeout(timeout)
  );

  rr_arb4 #(.MAX_HOLD(4), .HW(3)) u_dut4 (
    .i_clk(clk), .i_rst(rst4), .i_req(req4), .i_done(done4),
    .o_grant_idx(grant_idx4), .o_grant_en(grant_en4), .o_grant(grant4), .o_timeout(timeout4)
  );

  rr_arb4 #(.MAX_HOLD(1), .HW(2)) u_dut1 (
    .i_clk(clk), .i_rst(rst1), .i_req(req1), .i_done(done1),
    .o_grant_idx(grant_idx1), .o_grant_en(grant_en1), .o_grant(grant1), .o_timeout(timeout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks grant, grant_en and timeout of the main instance together.
  task automatic chk_main(input string tag, input logic [3:0] g, input logic t);
    check({tag, ".grant"}, {4'b0, grant}, {4'b0, g});
    check({tag, ".en"}, {7'b0, grant_en}, {7'b0, (g != 4'b0000)});
    check({tag, ".timeout"}, {7'b0, timeout}, {7'b0, t});
  endtask

  task automatic chk_4(input string tag, input logic [3:0] g, input logic t);
    check({tag, ".grant"}, {4'b0, grant4}, {4'b0, g});
    check({tag, ".timeout"}, {7'b0, timeout4}, {7'b0, t});
  endtask

  task automatic chk_1(input string tag, input logic [3:0] g, input logic t);
    check({tag, ".grant"}, {4'b0, grant1}, {4'b0, g});
    check({tag, ".timeout"}, {7'b0, timeout1}, {7'b0, t});
  endtask

  logic [3:0] seq [5];

  initial begin
    n_chk = 0;
    n_err = 0;
    rst  = 1'b1; req  = 4'b1111; done  = 1'b0;
    rst4 = 1'b1; req4 = 4'b0000; done4 = 1'b0;
    rst1 = 1'b1; req1 = 4'b0000; done1 = 1'b0;

    // Reset held two cycles with all requests up.
    tick(); chk_main("rst0", 4'b0000, 1'b0);
    check("rst0.idx", {6'b0, grant_idx}, 8'h00);
    tick(); chk_main("rst1", 4'b0000, 1'b0);
    rst = 1'b0;
    tick(); chk_main("first", 4'b0001, 1'b0);
    check("first.idx", {6'b0, grant_idx}, 8'h00);
    req = 4'b0000;
    tick(); chk_main("drop0", 4'b0000, 1'b0);

    // done while idle does nothing.
    done = 1'b1;
    tick(); chk_main("idle_done", 4'b0000, 1'b0);
    done = 1'b0;

    // Single requester 2, released by done on its third grant cycle.
    req = 4'b0100;
    tick(); chk_main("single.c1", 4'b0100, 1'b0);
    check("single.idx", {6'b0, grant_idx}, 8'h02);
    tick(); chk_main("single.c2", 4'b0100, 1'b0);
    tick(); chk_main("single.c3", 4'b0100, 1'b0);
    done = 1'b1;
    tick(); chk_main("single.rel", 4'b0000, 1'b0);
    done = 1'b0;
    tick(); chk_main("single.again", 4'b0100, 1'b0);
    done = 1'b1;
    tick(); chk_main("single.rel2", 4'b0000, 1'b0);
    done = 1'b0;

    // Full contention after a fresh reset: each owner holds 2 cycles.
    rst = 1'b1; req = 4'b1111;
    tick(); chk_main("cont.rst", 4'b0000, 1'b0);
    rst = 1'b0;
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000;
    seq[4] = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick(); chk_main($sformatf("cont%0d.a", i), seq[i], 1'b0);
      tick(); chk_main($sformatf("cont%0d.b", i), seq[i], 1'b0);
      done = 1'b1;
      tick(); chk_main($sformatf("cont%0d.gap", i), 4'b0000, 1'b0);
      done = 1'b0;
    end

    // ptr is now 1: grant 1 then drop it so ptr becomes 2.
    req = 4'b0010;
    tick(); chk_main("pre.g1", 4'b0010, 1'b0);
    req = 4'b0000;
    tick(); chk_main("pre.rel", 4'b0000, 1'b0);

    // Wrap and drop: 3 owns, req[3] drops, 0 next, then ptr=1 so 1 wins over 0.
    req = 4'b1001;
    tick(); chk_main("wrap.g3", 4'b1000, 1'b0);
    check("wrap.idx", {6'b0, grant_idx}, 8'h03);
    tick(); chk_main("wrap.g3b", 4'b1000, 1'b0);
    req = 4'b0001;
    tick(); chk_main("wrap.rel", 4'b0000, 1'b0);
    tick(); chk_main("wrap.g0", 4'b0001, 1'b0);
    done = 1'b1;
    tick(); chk_main("wrap.rel0", 4'b0000, 1'b0);
    done = 1'b0; req = 4'b1111;
    tick(); chk_main("wrap.ptr1", 4'b0010, 1'b0);
    check("wrap.ptr1.idx", {6'b0, grant_idx}, 8'h01);

    // Reset in the middle of a grant to requester 2.
    done = 1'b1;
    tick(); chk_main("mid.rel", 4'b0000, 1'b0);
    done = 1'b0;
    tick(); chk_main("mid.g2", 4'b0100, 1'b0);
    rst = 1'b1; done = 1'b1;
    tick(); chk_main("mid.rst", 4'b0000, 1'b0);
    check("mid.rst.idx", {6'b0, grant_idx}, 8'h00);
    rst = 1'b0; done = 1'b0;
    tick(); chk_main("mid.g0", 4'b0001, 1'b0);

    // Hold limit of 8 under contention, then a timeout and rotation to 1.
    for (int i = 1; i < 8; i++) begin
      tick(); chk_main($sformatf("hold8.c%0d", i + 1), 4'b0001, 1'b0);
    end
    tick(); chk_main("hold8.to", 4'b0000, 1'b1);
    tick(); chk_main("hold8.next", 4'b0010, 1'b0);
    req = 4'b0000;

    // MAX_HOLD=4: single requester 1 times out, then a done on cycle 4 suppresses it.
    tick(); chk_4("m4.rst", 4'b0000, 1'b0);
    rst4 = 1'b0; req4 = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      tick(); chk_4($sformatf("m4.c%0d", i + 1), 4'b0010, 1'b0);
    end
    tick(); chk_4("m4.to", 4'b0000, 1'b1);
    tick(); chk_4("m4.again", 4'b0010, 1'b0);
    tick(); chk_4("m4.r2", 4'b0010, 1'b0);
    tick(); chk_4("m4.r3", 4'b0010, 1'b0);
    tick(); chk_4("m4.r4", 4'b0010, 1'b0);
    done4 = 1'b1;
    tick(); chk_4("m4.done_no_to", 4'b0000, 1'b0);
    done4 = 1'b0; req4 = 4'b0000;
    tick(); chk_4("m4.idle", 4'b0000, 1'b0);

    // MAX_HOLD=1: single-cycle grants alternating with idle, each a timeout.
    tick(); chk_1("m1.rst", 4'b0000, 1'b0);
    rst1 = 1'b0; req1 = 4'b1111;
    tick(); chk_1("m1.g0", 4'b0001, 1'b0);
    tick(); chk_1("m1.gap0", 4'b0000, 1'b1);
    tick(); chk_1("m1.g1", 4'b0010, 1'b0);
    tick(); chk_1("m1.gap1", 4'b0000, 1'b1);
    tick(); chk_1("m1.g2", 4'b0100, 1'b0);
    req1 = 4'b0000;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
